// File: rtl/falu_pkg.sv
// Shared definitions for the FP ALU issue controller.
// Function codes, FSM states and the per-function latency lookup.
package falu_pkg;

  localparam logic [4:0] FC_FMADD   = 5'd0;
  localparam logic [4:0] FC_FNMADD  = 5'd1;
  localparam logic [4:0] FC_FMSUB   = 5'd2;
  localparam logic [4:0] FC_FNMSUB  = 5'd3;
  localparam logic [4:0] FC_ADD     = 5'd4;
  localparam logic [4:0] FC_SUB     = 5'd5;
  localparam logic [4:0] FC_MUL     = 5'd6;
  localparam logic [4:0] FC_DIV     = 5'd7;
  localparam logic [4:0] FC_FSQRT   = 5'd8;
  localparam logic [4:0] FC_FSGNJ   = 5'd9;
  localparam logic [4:0] FC_FSGNJN  = 5'd10;
  localparam logic [4:0] FC_FSGNJX  = 5'd11;
  localparam logic [4:0] FC_MIN_MAX = 5'd12;
  localparam logic [4:0] FC_CLASS   = 5'd13;
  localparam logic [4:0] FC_FMV_X_W = 5'd14;
  localparam logic [4:0] FC_FMV_W_X = 5'd15;
  localparam logic [4:0] IDLE_CODE  = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic int lat_of(
    input logic [4:0] func,
    input int         l_fma,
    input int         l_add,
    input int         l_mul,
    input int         l_div,
    input int         l_sqrt,
    input int         l_misc
  );
    int lat;
    lat = l_misc;
    case (func)
      FC_FMADD, FC_FNMADD,
      FC_FMSUB, FC_FNMSUB: lat = l_fma;
      FC_ADD, FC_SUB:      lat = l_add;
      FC_MUL:              lat = l_mul;
      FC_DIV:              lat = l_div;
      FC_FSQRT:            lat = l_sqrt;
      default:             lat = l_misc;
    endcase
    return lat;
  endfunction

  function automatic int lat_max(
    input int a,
    input int b,
    input int c,
    input int d,
    input int e,
    input int f
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

endpackage

// File: rtl/falu_result_sel.sv
// Picks the ALU result bus matching the held function code.
// Narrow results are zero-extended to the wide response width.
module falu_result_sel
  import falu_pkg::*;
#(
  parameter int OP_DATA_WIDTH = 32
) (
  input  logic [4:0]                 func,
  input  logic [OP_DATA_WIDTH-1:0]   in_fmadd,
  input  logic [OP_DATA_WIDTH-1:0]   in_fnmadd,
  input  logic [OP_DATA_WIDTH-1:0]   in_fmsub,
  input  logic [OP_DATA_WIDTH-1:0]   in_fnmsub,
  input  logic [OP_DATA_WIDTH-1:0]   in_add,
  input  logic [OP_DATA_WIDTH-1:0]   in_sub,
  input  logic [OP_DATA_WIDTH-1:0]   in_mul,
  input  logic [OP_DATA_WIDTH-1:0]   in_div,
  input  logic [OP_DATA_WIDTH-1:0]   in_fsqrt,
  input  logic [OP_DATA_WIDTH-1:0]   in_fsgnj,
  input  logic [OP_DATA_WIDTH-1:0]   in_fsgnjn,
  input  logic [OP_DATA_WIDTH-1:0]   in_fsgnjx,
  input  logic [OP_DATA_WIDTH-1:0]   in_min_max,
  input  logic [9:0]                 in_class,
  input  logic [2*OP_DATA_WIDTH-1:0] in_fmv_x_w,
  input  logic [OP_DATA_WIDTH-1:0]   in_fmv_w_x,
  output logic [2*OP_DATA_WIDTH-1:0] data
);

  localparam int W2 = 2 * OP_DATA_WIDTH;

  always_comb begin
    data = '0;
    unique case (func)
      FC_FMADD:   data = W2'(in_fmadd);
      FC_FNMADD:  data = W2'(in_fnmadd);
      FC_FMSUB:   data = W2'(in_fmsub);
      FC_FNMSUB:  data = W2'(in_fnmsub);
      FC_ADD:     data = W2'(in_add);
      FC_SUB:     data = W2'(in_sub);
      FC_MUL:     data = W2'(in_mul);
      FC_DIV:     data = W2'(in_div);
      FC_FSQRT:   data = W2'(in_fsqrt);
      FC_FSGNJ:   data = W2'(in_fsgnj);
      FC_FSGNJN:  data = W2'(in_fsgnjn);
      FC_FSGNJX:  data = W2'(in_fsgnjx);
      FC_MIN_MAX: data = W2'(in_min_max);
      FC_CLASS:   data = W2'(in_class);
      FC_FMV_X_W: data = in_fmv_x_w;
      FC_FMV_W_X: data = W2'(in_fmv_w_x);
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/falu_issue_ctrl.sv
// One-at-a-time request/response front end for the FP ALU.
// Holds operands and ALU_FUNC for the function latency, then returns the result.
module falu_issue_ctrl
  import falu_pkg::*;
#(
  parameter int OP_DATA_WIDTH = 32,
  parameter int LAT_FMA       = 1,
  parameter int LAT_ADD       = 1,
  parameter int LAT_MUL       = 1,
  parameter int LAT_DIV       = 1,
  parameter int LAT_SQRT      = 1,
  parameter int LAT_MISC      = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [4:0]                 REQ_FUNC,
  input  logic [OP_DATA_WIDTH-1:0]   REQ_A,
  input  logic [OP_DATA_WIDTH-1:0]   REQ_B,
  input  logic [OP_DATA_WIDTH-1:0]   REQ_C,
  input  logic [2*OP_DATA_WIDTH-1:0] REQ_A64,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic [2*OP_DATA_WIDTH-1:0] RSP_DATA,
  output logic [4:0]                 RSP_FUNC,
  output logic                       RSP_ERR,
  output logic [OP_DATA_WIDTH-1:0]   ALU_A,
  output logic [OP_DATA_WIDTH-1:0]   ALU_B,
  output logic [OP_DATA_WIDTH-1:0]   ALU_C,
  output logic [2*OP_DATA_WIDTH-1:0] ALU_A64,
  output logic [4:0]                 ALU_FUNC,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FMADD,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FNMADD,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FMSUB,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FNMSUB,
  input  logic [OP_DATA_WIDTH-1:0]   IN_ADD,
  input  logic [OP_DATA_WIDTH-1:0]   IN_SUB,
  input  logic [OP_DATA_WIDTH-1:0]   IN_MUL,
  input  logic [OP_DATA_WIDTH-1:0]   IN_DIV,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FSQRT,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FSGNJ,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FSGNJN,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FSGNJX,
  input  logic [OP_DATA_WIDTH-1:0]   IN_MIN_MAX,
  input  logic [9:0]                 IN_CLASS,
  input  logic [2*OP_DATA_WIDTH-1:0] IN_FMV_X_W,
  input  logic [OP_DATA_WIDTH-1:0]   IN_FMV_W_X
);

  localparam int MAXL = lat_max(LAT_FMA, LAT_ADD, LAT_MUL,
                                LAT_DIV, LAT_SQRT, LAT_MISC);
  localparam int CW   = $clog2(MAXL + 1);

  if (LAT_FMA < 1 || LAT_ADD < 1 || LAT_MUL < 1 ||
      LAT_DIV < 1 || LAT_SQRT < 1 || LAT_MISC < 1) begin : g_lat_chk
    $error("falu_issue_ctrl: every latency parameter must be >= 1");
  end

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic                       err_q;
  logic [2*OP_DATA_WIDTH-1:0] sel_data;
  logic                       accept;
  logic                       legal;

  assign accept = REQ_VALID & REQ_READY;
  assign legal  = ~REQ_FUNC[4];

  falu_result_sel #(
    .OP_DATA_WIDTH(OP_DATA_WIDTH)
  ) u_sel (
    .func      (ALU_FUNC),
    .in_fmadd  (IN_FMADD),
    .in_fnmadd (IN_FNMADD),
    .in_fmsub  (IN_FMSUB),
    .in_fnmsub (IN_FNMSUB),
    .in_add    (IN_ADD),
    .in_sub    (IN_SUB),
    .in_mul    (IN_MUL),
    .in_div    (IN_DIV),
    .in_fsqrt  (IN_FSQRT),
    .in_fsgnj  (IN_FSGNJ),
    .in_fsgnjn (IN_FSGNJN),
    .in_fsgnjx (IN_FSGNJX),
    .in_min_max(IN_MIN_MAX),
    .in_class  (IN_CLASS),
    .in_fmv_x_w(IN_FMV_X_W),
    .in_fmv_w_x(IN_FMV_W_X),
    .data      (sel_data)
  );

  // Illegal codes take the WAIT path with a zero count and no ALU activity.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_FUNC  <= '0;
      RSP_ERR   <= 1'b0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_C     <= '0;
      ALU_A64   <= '0;
      ALU_FUNC  <= IDLE_CODE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            REQ_READY <= 1'b0;
            RSP_FUNC  <= REQ_FUNC;
            state     <= S_WAIT;
            if (legal) begin
              ALU_A    <= REQ_A;
              ALU_B    <= REQ_B;
              ALU_C    <= REQ_C;
              ALU_A64  <= REQ_A64;
              ALU_FUNC <= REQ_FUNC;
              err_q    <= 1'b0;
              cnt      <= CW'(lat_of(REQ_FUNC, LAT_FMA, LAT_ADD,
                                     LAT_MUL, LAT_DIV, LAT_SQRT,
                                     LAT_MISC));
            end else begin
              err_q <= 1'b1;
              cnt   <= '0;
            end
          end else begin
            REQ_READY <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            RSP_DATA  <= err_q ? '0 : sel_data;
            RSP_ERR   <= err_q;
            RSP_VALID <= 1'b1;
            ALU_FUNC  <= IDLE_CODE;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falu_issue_ctrl.sv
// Scoreboard bench for falu_issue_ctrl with a stub ALU.
// Expected responses queue at acceptance and are matched on RSP_VALID rise.
module tb_falu_issue_ctrl;

  localparam int W = 32;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  func;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [4:0]    REQ_FUNC;
  logic [W-1:0]  REQ_A, REQ_B, REQ_C;
  logic [63:0]   REQ_A64;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [63:0]   RSP_DATA;
  logic [4:0]    RSP_FUNC;
  logic          RSP_ERR;
  logic [W-1:0]  ALU_A, ALU_B, ALU_C;
  logic [63:0]   ALU_A64;
  logic [4:0]    ALU_FUNC;
  logic [W-1:0]  IN_FMADD, IN_FNMADD, IN_FMSUB, IN_FNMSUB;
  logic [W-1:0]  IN_ADD, IN_SUB, IN_MUL, IN_DIV, IN_FSQRT;
  logic [W-1:0]  IN_FSGNJ, IN_FSGNJN, IN_FSGNJX, IN_MIN_MAX;
  logic [9:0]    IN_CLASS;
  logic [63:0]   IN_FMV_X_W;
  logic [W-1:0]  IN_FMV_W_X;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  falu_issue_ctrl #(
    .OP_DATA_WIDTH(W), .LAT_FMA(1), .LAT_ADD(1), .LAT_MUL(1),
    .LAT_DIV(3), .LAT_SQRT(1), .LAT_MISC(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_FUNC(REQ_FUNC), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_C(REQ_C), .REQ_A64(REQ_A64),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_FUNC(RSP_FUNC), .RSP_ERR(RSP_ERR),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_C(ALU_C),
    .ALU_A64(ALU_A64), .ALU_FUNC(ALU_FUNC),
    .IN_FMADD(IN_FMADD), .IN_FNMADD(IN_FNMADD),
    .IN_FMSUB(IN_FMSUB), .IN_FNMSUB(IN_FNMSUB),
    .IN_ADD(IN_ADD), .IN_SUB(IN_SUB), .IN_MUL(IN_MUL),
    .IN_DIV(IN_DIV), .IN_FSQRT(IN_FSQRT),
    .IN_FSGNJ(IN_FSGNJ), .IN_FSGNJN(IN_FSGNJN),
    .IN_FSGNJX(IN_FSGNJX), .IN_MIN_MAX(IN_MIN_MAX),
    .IN_CLASS(IN_CLASS), .IN_FMV_X_W(IN_FMV_X_W),
    .IN_FMV_W_X(IN_FMV_W_X)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [4:0] f,
                                        input logic [63:0] v);
    if (f == 5'd14) return v;
    if (f == 5'd13) return {54'd0, v[9:0]};
    return {32'd0, v[31:0]};
  endfunction

  // Every result bus carries a distinct junk value except the selected one.
  task automatic set_in(input logic [4:0] f, input logic [63:0] v);
    IN_FMADD   = 32'hA500_0000; IN_FNMADD  = 32'hA500_0001;
    IN_FMSUB   = 32'hA500_0002; IN_FNMSUB  = 32'hA500_0003;
    IN_ADD     = 32'hA500_0004; IN_SUB     = 32'hA500_0005;
    IN_MUL     = 32'hA500_0006; IN_DIV     = 32'hA500_0007;
    IN_FSQRT   = 32'hA500_0008; IN_FSGNJ   = 32'hA500_0009;
    IN_FSGNJN  = 32'hA500_000A; IN_FSGNJX  = 32'hA500_000B;
    IN_MIN_MAX = 32'hA500_000C; IN_CLASS   = 10'h2AA;
    IN_FMV_X_W = 64'h5A5A_5A5A_A500_000E;
    IN_FMV_W_X = 32'hA500_000F;
    case (f)
      5'd0:  IN_FMADD   = v[31:0];
      5'd1:  IN_FNMADD  = v[31:0];
      5'd2:  IN_FMSUB   = v[31:0];
      5'd3:  IN_FNMSUB  = v[31:0];
      5'd4:  IN_ADD     = v[31:0];
      5'd5:  IN_SUB     = v[31:0];
      5'd6:  IN_MUL     = v[31:0];
      5'd7:  IN_DIV     = v[31:0];
      5'd8:  IN_FSQRT   = v[31:0];
      5'd9:  IN_FSGNJ   = v[31:0];
      5'd10: IN_FSGNJN  = v[31:0];
      5'd11: IN_FSGNJX  = v[31:0];
      5'd12: IN_MIN_MAX = v[31:0];
      5'd13: IN_CLASS   = v[9:0];
      5'd14: IN_FMV_X_W = v;
      5'd15: IN_FMV_W_X = v[31:0];
      default: ;
    endcase
  endtask

  task automatic issue(input logic [4:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic [63:0] a64, input logic [63:0] v,
                       input int lat);
    exp_t e;
    int   n;
    set_in(f, v);
    REQ_FUNC = f; REQ_A = a; REQ_B = b; REQ_C = c; REQ_A64 = a64;
    REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready", 64'(REQ_READY), 64'd1);
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    e.func = f;
    e.err  = f[4];
    e.data = f[4] ? 64'd0 : model(f, v);
    e.lat  = lat;
    e.acc  = cyc;
    sb.push_back(e);
    chk("alu_func_acc", 64'(ALU_FUNC), f[4] ? 64'd31 : 64'(f));
    if (!f[4]) begin
      chk("alu_a", 64'(ALU_A), 64'(a));
      chk("alu_b", 64'(ALU_B), 64'(b));
      chk("alu_c", 64'(ALU_C), 64'(c));
      chk("alu_a64", ALU_A64, a64);
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rsp_timeout", 64'(sb.size()), 64'd0);
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (RSP_VALID && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 64'(RSP_VALID), 64'd0);
      end else begin
        chk("rsp_data", RSP_DATA, sb[0].data);
        chk("rsp_func", 64'(RSP_FUNC), 64'(sb[0].func));
        chk("rsp_err", 64'(RSP_ERR), 64'(sb[0].err));
        chk("rsp_lat", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        void'(sb.pop_front());
      end
    end
    prev_valid <= RSP_VALID;
  end

  logic [4:0]  t_f[6] = '{5'd0, 5'd5, 5'd6, 5'd8, 5'd11, 5'd15};
  logic [63:0] t_v[6] = '{64'hFFFF_0000_C0A0_0000, 64'h1234_0000_BF80_0000,
                          64'h0000_0001_40C0_0000, 64'hFFFF_FFFF_3FB5_04F3,
                          64'h8000_0000_8000_0001, 64'h0BAD_F00D_1357_9BDF};

  initial begin
    REQ_VALID = 1'b0; REQ_FUNC = '0; REQ_A = '0; REQ_B = '0;
    REQ_C = '0; REQ_A64 = '0; RSP_READY = 1'b1;
    set_in(5'd31, 64'd0);
    #1 RST = 1'b0;
    #2;
    chk("rst_req_ready", 64'(REQ_READY), 64'd0);
    chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("rst_alu_func", 64'(ALU_FUNC), 64'd31);
    chk("rst_rsp_data", RSP_DATA, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_hold_ready", 64'(REQ_READY), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("ready_rise", 64'(REQ_READY), 64'd1);

    issue(5'd4, 32'h3F80_0000, 32'h4000_0000, 32'd0, 64'd0,
          64'hFFFF_0000_4040_0000, 2);
    wait_rsp();

    for (int i = 0; i < 6; i++) begin
      issue(t_f[i], 32'h1000_0000 + i, 32'h2000_0000 + i,
            32'h3000_0000 + i, 64'hCAFE_0000_0000_0000 + 64'(i),
            t_v[i], 2);
      wait_rsp();
    end

    issue(5'd7, 32'h40C0_0000, 32'h4000_0000, 32'd0, 64'd0,
          64'h0000_0000_4040_0000, 4);
    for (int k = 0; k < 4; k++) begin
      chk("div_func_hold", 64'(ALU_FUNC), 64'd7);
      chk("div_a_hold", 64'(ALU_A), 64'h40C0_0000);
      @(negedge CLK);
    end
    chk("div_func_idle", 64'(ALU_FUNC), 64'd31);
    wait_rsp();

    issue(5'd20, 32'hDEAD_BEEF, 32'd1, 32'd2, 64'd3, 64'hFFFF_FFFF, 1);
    wait_rsp();
    chk("ill_func_idle", 64'(ALU_FUNC), 64'd31);

    issue(5'd14, 32'd0, 32'd0, 32'd0, 64'h0011_2233_4455_6677,
          64'h0123_4567_89AB_CDEF, 2);
    wait_rsp();

    RSP_READY = 1'b0;
    issue(5'd13, 32'hFF80_0000, 32'd0, 32'd0, 64'd0,
          64'hFFFF_FFFF_FFFF_FC01, 2);
    begin
      int n;
      n = 0;
      while (!RSP_VALID && n < 20) begin
        @(negedge CLK);
        n++;
      end
    end
    chk("bp_valid", 64'(RSP_VALID), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_data", RSP_DATA, 64'd1);
      chk("bp_req_ready", 64'(REQ_READY), 64'd0);
      @(negedge CLK);
    end
    RSP_READY = 1'b1;
    @(negedge CLK);
    chk("bp_idle_ready", 64'(REQ_READY), 64'd1);
    chk("bp_valid_drop", 64'(RSP_VALID), 64'd0);

    issue(5'd7, 32'h40C0_0000, 32'h4000_0000, 32'd0, 64'd0,
          64'h0000_0000_4040_0000, 4);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(REQ_READY), 64'd0);
    chk("mid_rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("mid_rst_alu_func", 64'(ALU_FUNC), 64'd31);
    chk("mid_rst_alu_a", 64'(ALU_A), 64'd0);
    chk("mid_rst_rsp_func", 64'(RSP_FUNC), 64'd0);
    chk("mid_rst_rsp_data", RSP_DATA, 64'd0);
    sb.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (8) @(negedge CLK);
    chk("post_rst_ready", 64'(REQ_READY), 64'd1);

    issue(5'd4, 32'h3F80_0000, 32'h4000_0000, 32'd0, 64'd0,
          64'h0000_0000_4040_0000, 2);
    wait_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
